hazard_scoreboard: RTL

Parametrised hazard controller for the pipelined ARM core. It replaces fixed-latency load-use detection with a per-register latency scoreboard, so the pipeline tolerates result-producing operations of variable latency (loads, multi-cycle ALU ops). It sits beside the decode stage and drives the fetch/decode stall and decode/execute flush controls. It also accepts a pipeline-wide freeze for slow memory.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/sb_counter.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 87 ++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard: default geometry, the PC register
// index and the latency-counter width derivation.
package hazard_pkg;

  localparam int NREG_DEF   = 16;
  localparam int AW_DEF     = 4;
  localparam int MAXLAT_DEF = 4;
  localparam int PC_IDX     = 15;

  // A counter must hold every value 0..maxlat; never narrower than one bit.
  function automatic int lat_width(input int maxlat);
    return (maxlat < 1) ? 1 : $clog2(maxlat + 1);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register latency counter: load on accepted write, hold on freeze,
// otherwise count down to zero and stay there.
module sb_counter #(
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [LW-1:0] load_val_i,
  input  logic          hold_i,
  input  logic          dec_i,
  output logic [LW-1:0] cnt_o,
  output logic          busy_o
);

  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;

  // Freeze beats a load so a frozen decode slot never leaves an entry behind.
  always_comb begin
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = |cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard controller: per-register latency scoreboard producing
// stall/flush controls for fetch, decode and execute.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int AW     = AW_DEF,
  parameter int NSRC   = 3,
  parameter int MAXLAT = MAXLAT_DEF,
  parameter int LW     = lat_width(MAXLAT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic [NSRC*AW-1:0]   iss_src,
  input  logic [NSRC-1:0]      iss_src_en,
  input  logic                 iss_we,
  input  logic [AW-1:0]        iss_rd,
  input  logic [LW-1:0]        iss_lat,
  input  logic                 br_taken_e,
  input  logic                 freeze,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [NREG-1:0]      busy_mask
);

  logic [NREG*LW-1:0] cnt_flat;
  logic [LW-1:0]      lat_c;
  logic [LW-1:0]      rd_cnt;
  logic [NSRC-1:0]    src_busy;
  logic               raw;
  logic               waw;
  logic               hz;
  logic               accept;

  assign lat_c = (iss_lat > LW'(MAXLAT)) ? LW'(MAXLAT) : iss_lat;

  // Lookups by comparison against each real register index: addresses at or
  // above NREG match nothing and therefore read as not busy.
  always_comb begin
    rd_cnt   = '0;
    src_busy = '0;
    for (int r = 0; r < NREG; r++) begin
      if (iss_rd == AW'(r)) begin
        rd_cnt = cnt_flat[r*LW +: LW];
      end
      for (int j = 0; j < NSRC; j++) begin
        if (iss_src_en[j] && (iss_src[j*AW +: AW] == AW'(r)) &&
            (cnt_flat[r*LW +: LW] != '0)) begin
          src_busy[j] = 1'b1;
        end
      end
    end
  end

  assign raw = |src_busy;
  assign waw = iss_we && (rd_cnt > lat_c);
  assign hz  = iss_valid && (raw || waw);

  // A taken branch squashes decode, so it overrides the hazard stall.
  assign stall_d = freeze || (hz && !br_taken_e);
  assign stall_f = stall_d;
  assign flush_d = br_taken_e && !freeze;
  assign flush_e = (br_taken_e || hz) && !freeze;
  assign accept  = iss_valid && !hz && !br_taken_e && !freeze;

  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    logic ld;
    assign ld = accept && iss_we && (iss_rd == AW'(r));

    sb_counter #(
      .LW (LW)
    ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (ld),
      .load_val_i (lat_c),
      .hold_i     (freeze),
      .dec_i      (1'b1),
      .cnt_o      (cnt_flat[r*LW +: LW]),
      .busy_o     (busy_mask[r])
    );
  end

endmodule
